// File: rtl/asteroids_stage_controller_pkg.sv
// rtl/asteroids_stage_controller_pkg.sv - shared stage-controller types
// State encoding reused by every stage controller in the game.
package asteroids_stage_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESPAWN,
    ST_INTRO,
    ST_PLAY,
    ST_OUTRO,
    ST_DONE
  } stage_state_t;

endpackage

// File: rtl/asteroids_stage_controller_timer.sv
// rtl/asteroids_stage_controller_timer.sv - frame counter and seconds countdown
// Counts frames while not frozen and decrements seconds_left on each wrap.
module frame_second_timer #(
  parameter int FRAMES_PER_SECOND  = 60,
  parameter int TIME_LIMIT_SECONDS = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sof_i,
  input  logic       load_i,
  input  logic       clear_i,
  input  logic       freeze_i,
  output logic [5:0] seconds_left_o,
  output logic       expire_o
);

  localparam int FW = (FRAMES_PER_SECOND > 1) ? $clog2(FRAMES_PER_SECOND) : 1;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          tick, wrap;

  assign tick           = sof_i && !freeze_i;
  assign wrap           = tick && (frame_cnt_q == FW'(FRAMES_PER_SECOND - 1));
  // Expiry is flagged in the same frame the last second runs out.
  assign expire_o       = wrap && (seconds_q == 6'd1);
  assign seconds_left_o = seconds_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    seconds_d   = seconds_q;
    if (clear_i) begin
      frame_cnt_d = '0;
      seconds_d   = '0;
    end else if (load_i) begin
      frame_cnt_d = '0;
      seconds_d   = 6'(TIME_LIMIT_SECONDS);
    end else if (wrap) begin
      frame_cnt_d = '0;
      if (seconds_q != 6'd0) seconds_d = seconds_q - 6'd1;
    end else if (tick) begin
      frame_cnt_d = frame_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
      seconds_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      seconds_q   <= seconds_d;
    end
  end

endmodule

// File: rtl/asteroids_stage_controller.sv
// rtl/asteroids_stage_controller.sv - stage sequencer between game FSM and asteroid field
// Respawns and gates the field, awards points, runs the stage timer, reports the result.
module asteroids_stage_controller
  import asteroids_stage_controller_pkg::*;
#(
  parameter int FRAMES_PER_SECOND   = 60,
  parameter int TIME_LIMIT_SECONDS  = 30,
  parameter int INTRO_FRAMES        = 90,
  parameter int OUTRO_FRAMES        = 12,
  parameter int POINTS_PER_ASTEROID = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       stage_start,
  input  logic       stage_abort,
  input  logic       asteroid_exploded_pulse,
  input  logic       all_asteroids_destroied,
  output logic       asteroids_resetN,
  output logic       asteroids_enable,
  output logic [7:0] score_add,
  output logic [5:0] seconds_left,
  output logic       stage_active,
  output logic       stage_won,
  output logic       stage_lost
);

  localparam int PHASE_MAX = (INTRO_FRAMES > OUTRO_FRAMES) ? INTRO_FRAMES : OUTRO_FRAMES;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  stage_state_t  state_q, state_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic          won_q, won_d;
  logic          field_resetN_q, field_resetN_d;
  logic          enable_q, enable_d;
  logic [7:0]    score_q, score_d;
  logic          active_q, active_d;
  logic          won_pulse_q, won_pulse_d;
  logic          lost_pulse_q, lost_pulse_d;
  logic          expire;
  logic          in_field_play;

  frame_second_timer #(
    .FRAMES_PER_SECOND (FRAMES_PER_SECOND),
    .TIME_LIMIT_SECONDS(TIME_LIMIT_SECONDS)
  ) u_timer (
    .clk           (clk),
    .resetN        (resetN),
    .sof_i         (startOfFrame),
    .load_i        (state_d == ST_RESPAWN),
    .clear_i       (state_d == ST_IDLE),
    .freeze_i      (state_q != ST_PLAY),
    .seconds_left_o(seconds_left),
    .expire_o      (expire)
  );

  assign in_field_play = (state_q == ST_PLAY) || (state_q == ST_OUTRO);

  always_comb begin
    state_d = state_q;
    won_d   = won_q;
    case (state_q)
      ST_IDLE:    if (stage_start) state_d = ST_RESPAWN;
      ST_RESPAWN: state_d = ST_INTRO;
      ST_INTRO: begin
        if (startOfFrame && phase_cnt_q == PW'(INTRO_FRAMES - 1)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A kill wins even when the clock runs out in the same frame.
        if (all_asteroids_destroied) begin
          state_d = ST_OUTRO;
        end else if (expire) begin
          state_d = ST_DONE;
          won_d   = 1'b0;
        end
      end
      ST_OUTRO: begin
        if (startOfFrame && phase_cnt_q == PW'(OUTRO_FRAMES - 1)) begin
          state_d = ST_DONE;
          won_d   = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (stage_abort) state_d = ST_IDLE;

    phase_cnt_d = phase_cnt_q;
    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if (startOfFrame && (state_q == ST_INTRO || state_q == ST_OUTRO)) begin
      phase_cnt_d = phase_cnt_q + PW'(1);
    end

    field_resetN_d = (state_d != ST_RESPAWN);
    enable_d       = (state_d == ST_PLAY) || (state_d == ST_OUTRO);
    active_d       = (state_d != ST_IDLE);
    won_pulse_d    = (state_q == ST_DONE) && won_q && !stage_abort;
    lost_pulse_d   = (state_q == ST_DONE) && !won_q && !stage_abort;
    score_d        = (asteroid_exploded_pulse && in_field_play) ? 8'(POINTS_PER_ASTEROID) : 8'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_IDLE;
      phase_cnt_q    <= '0;
      won_q          <= 1'b0;
      field_resetN_q <= 1'b1;
      enable_q       <= 1'b0;
      score_q        <= 8'd0;
      active_q       <= 1'b0;
      won_pulse_q    <= 1'b0;
      lost_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_cnt_q    <= phase_cnt_d;
      won_q          <= won_d;
      field_resetN_q <= field_resetN_d;
      enable_q       <= enable_d;
      score_q        <= score_d;
      active_q       <= active_d;
      won_pulse_q    <= won_pulse_d;
      lost_pulse_q   <= lost_pulse_d;
    end
  end

  assign asteroids_resetN = field_resetN_q;
  assign asteroids_enable = enable_q;
  assign score_add        = score_q;
  assign stage_active     = active_q;
  assign stage_won        = won_pulse_q;
  assign stage_lost       = lost_pulse_q;

endmodule

// File: tb/tb_asteroids_stage_controller.sv
// tb/tb_asteroids_stage_controller.sv - self-checking bench for asteroids_stage_controller
// Score awards and stage results are scoreboarded; timing points are checked directly.
module tb_asteroids_stage_controller;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       stage_start = 1'b0;
  logic       stage_abort = 1'b0;
  logic       asteroid_exploded_pulse = 1'b0;
  logic       all_asteroids_destroied = 1'b0;
  logic       asteroids_resetN;
  logic       asteroids_enable;
  logic [7:0] score_add;
  logic [5:0] seconds_left;
  logic       stage_active;
  logic       stage_won;
  logic       stage_lost;

  int n_vec = 0;
  int n_err = 0;
  int score_q[$];
  int result_q[$];

  always #5 clk = ~clk;

  asteroids_stage_controller dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .stage_start            (stage_start),
    .stage_abort            (stage_abort),
    .asteroid_exploded_pulse(asteroid_exploded_pulse),
    .all_asteroids_destroied(all_asteroids_destroied),
    .asteroids_resetN       (asteroids_resetN),
    .asteroids_enable       (asteroids_enable),
    .score_add              (score_add),
    .seconds_left           (seconds_left),
    .stage_active           (stage_active),
    .stage_won              (stage_won),
    .stage_lost             (stage_lost)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      repeat (3) tick();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end
  endtask

  task automatic start_stage();
    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
    tick();
    frames(90);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resetN"}, asteroids_resetN, 1);
    check({tag, "_enable"}, asteroids_enable, 0);
    check({tag, "_score"}, score_add, 0);
    check({tag, "_secs"}, seconds_left, 0);
    check({tag, "_active"}, stage_active, 0);
    check({tag, "_won"}, stage_won, 0);
    check({tag, "_lost"}, stage_lost, 0);
  endtask

  // Scoreboard: every award and every result pulse must match a queued expectation.
  always @(negedge clk) begin
    if (score_add != 8'd0) begin
      if (score_q.size() == 0) check("sb_score_spurious", score_add, 0);
      else check("sb_score", score_add, score_q.pop_front());
    end
    if (stage_won || stage_lost) begin
      if (result_q.size() == 0) begin
        check("sb_result_spurious", 1, 0);
      end else begin
        int r;
        r = result_q.pop_front();
        check("sb_won", stage_won, r);
        check("sb_lost", stage_lost, 1 - r);
      end
    end
  end

  initial begin
    repeat (3) tick();
    check_reset_outputs("rst");
    resetN = 1'b1;
    tick();

    // Stage 1: start, intro, scoring, ignored start, win.
    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
    check("respawn_resetN", asteroids_resetN, 0);
    check("respawn_active", stage_active, 1);
    check("respawn_secs", seconds_left, 30);
    check("respawn_enable", asteroids_enable, 0);
    tick();
    check("intro_resetN", asteroids_resetN, 1);
    frames(89);
    check("intro_enable_89", asteroids_enable, 0);
    frames(1);
    check("play_enable_90", asteroids_enable, 1);

    for (int k = 0; k < 3; k++) begin
      asteroid_exploded_pulse = 1'b1;
      score_q.push_back(5);
      tick();
      asteroid_exploded_pulse = 1'b0;
      check("score_latency", score_add, 5);
      tick();
      check("score_clear", score_add, 0);
      tick();
    end

    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
    check("midplay_start_resetN", asteroids_resetN, 1);
    check("midplay_start_enable", asteroids_enable, 1);
    check("midplay_start_secs", seconds_left, 30);

    all_asteroids_destroied = 1'b1;
    result_q.push_back(1);
    tick();
    all_asteroids_destroied = 1'b0;
    check("outro_enable", asteroids_enable, 1);
    frames(11);
    check("outro_enable_11", asteroids_enable, 1);
    check("outro_active_11", stage_active, 1);
    frames(1);
    check("done_enable", asteroids_enable, 0);
    check("done_won_early", stage_won, 0);
    tick();
    check("win_pulse", stage_won, 1);
    check("win_not_lost", stage_lost, 0);
    check("win_active", stage_active, 0);
    tick();
    check("win_pulse_end", stage_won, 0);

    // Stage 2: timeout.
    start_stage();
    check("s2_play_enable", asteroids_enable, 1);
    frames(59);
    check("s2_secs_59", seconds_left, 30);
    frames(1);
    check("s2_secs_60", seconds_left, 29);
    frames(1739);
    check("s2_secs_1799", seconds_left, 1);
    check("s2_enable_1799", asteroids_enable, 1);
    result_q.push_back(0);
    frames(1);
    check("s2_secs_zero", seconds_left, 0);
    check("s2_enable_drop", asteroids_enable, 0);
    check("s2_lost_early", stage_lost, 0);
    tick();
    check("lose_pulse", stage_lost, 1);
    check("lose_not_won", stage_won, 0);
    check("lose_active", stage_active, 0);
    tick();
    check("lose_pulse_end", stage_lost, 0);

    // Stage 3: kill in the same frame the clock runs out.
    start_stage();
    frames(1799);
    check("s3_secs_1799", seconds_left, 1);
    repeat (3) tick();
    startOfFrame = 1'b1;
    all_asteroids_destroied = 1'b1;
    result_q.push_back(1);
    tick();
    startOfFrame = 1'b0;
    all_asteroids_destroied = 1'b0;
    check("tie_enable", asteroids_enable, 1);
    check("tie_lost", stage_lost, 0);
    tick();
    check("tie_lost_late", stage_lost, 0);
    frames(12);
    tick();
    check("tie_won", stage_won, 1);
    check("tie_not_lost", stage_lost, 0);

    // Stage 4: abort during outro.
    start_stage();
    all_asteroids_destroied = 1'b1;
    tick();
    all_asteroids_destroied = 1'b0;
    frames(3);
    check("abort_pre_enable", asteroids_enable, 1);
    stage_abort = 1'b1;
    tick();
    stage_abort = 1'b0;
    check("abort_enable", asteroids_enable, 0);
    check("abort_active", stage_active, 0);
    frames(15);
    check("abort_won", stage_won, 0);
    check("abort_lost", stage_lost, 0);

    // Asynchronous reset mid-stage.
    stage_start = 1'b1;
    tick();
    stage_start = 1'b0;
    frames(100);
    check("pre_reset_enable", asteroids_enable, 1);
    #2;
    resetN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    resetN = 1'b1;
    repeat (4) tick();
    check("post_reset_active", stage_active, 0);

    check("score_queue_empty", score_q.size(), 0);
    check("result_queue_empty", result_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/asteroids_stage_controller.md
# asteroids_stage_controller

Sequencer on the controlling side of the asteroid field's enable/result interface. It respawns the field, gates its enable, and consumes `asteroid_exploded_pulse` and `all_asteroids_destroied` to award points. It runs the stage timer and reports win, loss or abort to the top-level game FSM. It sits between the game FSM and the asteroid field and is clocked by the pixel clock, advancing on `startOfFrame`.

## Interface
- FRAMES_PER_SECOND, 60, frames per timer second
- TIME_LIMIT_SECONDS, 30, stage duration; range 1..63
- INTRO_FRAMES, 90, frames the field is held frozen after start
- OUTRO_FRAMES, 12, frames enable stays high after the last kill so explosions animate; must be ≥ field deactivation delay (10) + 1
- POINTS_PER_ASTEROID, 5, added to score per explosion pulse
- clk  in  1  pixel clock; the only clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- stage_start  in  1  one-cycle request from the game FSM; honoured only in IDLE
- stage_abort  in  1  level; the player died; forces IDLE from any state
- asteroid_exploded_pulse  in  1  from the field
- all_asteroids_destroied  in  1  level from the field
- asteroids_resetN  out  1  active-low soft reset to the field; reset value 1
- asteroids_enable  out  1  gates the field's frame pulse; reset value 0
- score_add  out  8  points to add this cycle; reset value 0
- seconds_left  out  6  display value; reset value 0
- stage_active  out  1  high outside IDLE; reset value 0
- stage_won  out  1  one-cycle pulse; reset value 0
- stage_lost  out  1  one-cycle pulse; reset value 0

## Operation
- FSM states: IDLE, RESPAWN, INTRO, PLAY, OUTRO, DONE.
- IDLE: all outputs 0, `asteroids_resetN`=1. `stage_start` → RESPAWN.
- RESPAWN: exactly one cycle with `asteroids_resetN`=0. Load `frame_cnt`=0 and `seconds_left`=TIME_LIMIT_SECONDS. Next state is INTRO.
- INTRO: enable=0. Count frames on `startOfFrame`. After INTRO_FRAMES frames → PLAY.
- PLAY: enable=1.
  - `frame_cnt` increments per frame and wraps at FRAMES_PER_SECOND-1. On each wrap, `seconds_left` decrements.
  - A kill (`all_asteroids_destroied`) → OUTRO, frame counter cleared.
  - A frame in which `seconds_left` reaches 0 → DONE with result "lost".
  - If kill and timeout occur in the same frame, win takes priority.
- OUTRO: enable=1 and the timer is frozen. After OUTRO_FRAMES frames → DONE with result "won".
- DONE: pulse `stage_won` or `stage_lost` for one cycle. Next state is IDLE.
- `score_add` = POINTS_PER_ASTEROID for the cycle after each `asteroid_exploded_pulse` seen in PLAY or OUTRO, otherwise 0. Pulses in other states are ignored.
- Several asteroids exploding in the same cycle produce a single pulse and therefore a single award. This is accepted behaviour.
- `stage_abort` takes priority over every transition: next state IDLE, no result pulse, `asteroids_enable` drops next cycle.
- `stage_start` outside IDLE is ignored.
- `all_asteroids_destroied` while in INTRO is ignored. It can only occur from a stale field, and RESPAWN clears the field.

## Timing
- All outputs are registered. State changes take effect on the clock edge after the qualifying input.
- `stage_start` at edge N: `asteroids_resetN` is low during cycle N+1 and `stage_active` is high from N+1.
- INTRO → PLAY occurs on the clock edge following the INTRO_FRAMES-th `startOfFrame` after entering INTRO.
- Result pulse latency: 2 cycles after the deciding `startOfFrame` (transition to DONE, then pulse).
- `score_add` latency: 1 cycle.
- Reset mid-stage returns to IDLE with every output at its reset value.

## Structure
- The `stage_state_t` enum goes in the shared parameters package. The other stage controllers reuse it.
- One sub-module, `frame_second_timer`, holds the frame counter and `seconds_left`, with load, freeze and expire ports. The FSM stays in this block.

## Test plan
- Reset, then `stage_start` → one cycle of `asteroids_resetN`=0, `stage_active`=1, `seconds_left`=30, enable=0 for 90 frames and then 1.
- In PLAY, 3 separate exploded pulses → three `score_add`=5 cycles, each one cycle after its pulse.
- Assert `all_asteroids_destroied` in PLAY → enable stays high 12 more frames, then `stage_won` pulses once and `stage_active` drops.
- No kills → `seconds_left` falls by 1 every 60 frames. At 0, `stage_lost` pulses and enable drops.
- Kill in the same frame `seconds_left` hits 0 → `stage_won`, not `stage_lost`.
- `stage_abort` during OUTRO → IDLE next cycle with no result pulse. A `stage_start` issued mid-PLAY is ignored.
